// File: rtl/lcd_update_scheduler_if.sv
// Bundle between the pet game logic / bring-up harness and the LCD update
// scheduler.
//   master : drives tick, test_mode and the requested fields (*_in),
//            observes the committed fields, update_strobe and busy.
//   slave  : the scheduler itself.
// Field widths follow NUM_FACES / MAX_VALUE.
interface lcd_update_scheduler_if #(
  parameter int NUM_FACES = 9,
  parameter int MAX_VALUE = 5
);
  localparam int FW = $clog2(NUM_FACES);
  localparam int VW = $clog2(MAX_VALUE + 1);

  logic          tick;
  logic          test_mode;
  logic [FW-1:0] face_in;
  logic [VW-1:0] feed_in;
  logic [VW-1:0] joy_in;
  logic [VW-1:0] energy_in;
  logic [FW-1:0] face;
  logic [VW-1:0] feed_value;
  logic [VW-1:0] joy_value;
  logic [VW-1:0] energy_value;
  logic          update_strobe;
  logic          busy;

  modport master (
    output tick, test_mode, face_in, feed_in, joy_in, energy_in,
    input  face, feed_value, joy_value, energy_value, update_strobe, busy
  );

  modport slave (
    input  tick, test_mode, face_in, feed_in, joy_in, energy_in,
    output face, feed_value, joy_value, energy_value, update_strobe, busy
  );
endinterface

// File: rtl/lcd_update_scheduler.sv
// Rate-limited scheduler feeding the LCD1602 controller's face/value inputs.
// Commits at most one changed field (face > feed > joy > energy) per
// HOLD_TICKS display ticks. A sweep mode (test_mode) steps through every
// face glyph and bar level for board bring-up.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    lcd_update_scheduler_if.slave: tick, test_mode, *_in requests in;
//          face/feed_value/joy_value/energy_value, update_strobe, busy out
// The interface instance must carry the same NUM_FACES / MAX_VALUE.
module lcd_update_scheduler #(
  parameter int NUM_FACES  = 9,
  parameter int MAX_VALUE  = 5,
  parameter int HOLD_TICKS = 80
) (
  input  logic                  clk,
  input  logic                  reset,
  lcd_update_scheduler_if.slave bus
);
  localparam int FW     = $clog2(NUM_FACES);
  localparam int VW     = $clog2(MAX_VALUE + 1);
  localparam int CW     = $clog2(HOLD_TICKS + 1);
  localparam int NV     = MAX_VALUE + 1;
  localparam int S      = 2 + NUM_FACES + 3 * NV;
  localparam int SW     = $clog2(S);
  // Sweep segment boundaries (first step past each segment).
  localparam int F_END  = 2 + NUM_FACES;
  localparam int FD_END = F_END + NV;
  localparam int JY_END = FD_END + NV;

  typedef enum logic [1:0] {IDLE, HOLD, TEST} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] step;
  logic [FW-1:0] face_q;
  logic [VW-1:0] feed_q, joy_q, energy_q;
  logic          strobe_q, busy_q;

  // Clamped live requests.
  logic [FW-1:0] c_face;
  logic [VW-1:0] c_feed, c_joy, c_energy;

  // Sweep: next step index and the field values it leaves behind.
  logic [SW-1:0] step_nxt;
  int            s_nxt;
  logic [FW-1:0] t_face;
  logic [VW-1:0] t_feed, t_joy, t_energy;
  logic          t_chg;

  always_comb begin
    c_face   = (int'(bus.face_in) >= NUM_FACES) ? FW'(NUM_FACES - 1) : bus.face_in;
    c_feed   = (int'(bus.feed_in) > MAX_VALUE) ? VW'(MAX_VALUE) : bus.feed_in;
    c_joy    = (int'(bus.joy_in) > MAX_VALUE) ? VW'(MAX_VALUE) : bus.joy_in;
    c_energy = (int'(bus.energy_in) > MAX_VALUE) ? VW'(MAX_VALUE) : bus.energy_in;
  end

  always_comb begin
    step_nxt = (step == SW'(S - 1)) ? '0 : step + SW'(1);
    s_nxt    = int'(step_nxt);
    t_face   = face_q;
    t_feed   = feed_q;
    t_joy    = joy_q;
    t_energy = energy_q;
    // Steps 0 and 1 are deliberate no-change steps.
    if (s_nxt >= 2 && s_nxt < F_END)        t_face   = FW'(s_nxt - 2);
    else if (s_nxt >= F_END && s_nxt < FD_END)  t_feed   = VW'(s_nxt - F_END);
    else if (s_nxt >= FD_END && s_nxt < JY_END) t_joy    = VW'(s_nxt - FD_END);
    else if (s_nxt >= JY_END)                   t_energy = VW'(s_nxt - JY_END);
    t_chg = (t_face != face_q) || (t_feed != feed_q) ||
            (t_joy != joy_q) || (t_energy != energy_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      step     <= '0;
      face_q   <= '0;
      feed_q   <= VW'(MAX_VALUE);
      joy_q    <= VW'(MAX_VALUE);
      energy_q <= VW'(MAX_VALUE);
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      unique case (state)
        IDLE: begin
          // Ticks are ignored here, so a tick on the commit edge never
          // shortens the hold that commit starts.
          if (bus.test_mode) begin
            state  <= TEST;
            step   <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else if (c_face != face_q || c_feed != feed_q ||
                       c_joy != joy_q || c_energy != energy_q) begin
            if (c_face != face_q)      face_q   <= c_face;
            else if (c_feed != feed_q) feed_q   <= c_feed;
            else if (c_joy != joy_q)   joy_q    <= c_joy;
            else                       energy_q <= c_energy;
            strobe_q <= 1'b1;
            cnt      <= CW'(HOLD_TICKS);
            state    <= HOLD;
            busy_q   <= 1'b1;
          end
        end
        HOLD: begin
          // Requests are not latched; IDLE re-compares live inputs.
          if (bus.tick) begin
            if (cnt <= CW'(1)) begin
              cnt    <= '0;
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        TEST: begin
          // Counts up within a step; test_mode only matters at boundaries.
          if (bus.tick) begin
            if (cnt == CW'(HOLD_TICKS - 1)) begin
              cnt <= '0;
              if (!bus.test_mode) begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                step     <= step_nxt;
                face_q   <= t_face;
                feed_q   <= t_feed;
                joy_q    <= t_joy;
                energy_q <= t_energy;
                strobe_q <= t_chg;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.face          = face_q;
  assign bus.feed_value    = feed_q;
  assign bus.joy_value     = joy_q;
  assign bus.energy_value  = energy_q;
  assign bus.update_strobe = strobe_q;
  assign bus.busy          = busy_q;
endmodule

// File: tb/tb_lcd_update_scheduler.sv
module tb_lcd_update_scheduler;
  localparam int NF = 9;
  localparam int MV = 5;
  localparam int HT = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic seen3 = 1'b0;

  lcd_update_scheduler_if #(.NUM_FACES(NF), .MAX_VALUE(MV)) bus ();

  lcd_update_scheduler #(.NUM_FACES(NF), .MAX_VALUE(MV), .HOLD_TICKS(HT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Flags any appearance of feed level 3 (must never be shown).
  always @(negedge clk) if (bus.feed_value == 3'd3) seen3 <= 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    bus.tick = 1'b1;
    cyc(n);
    bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int f, input int fd, input int j,
                         input int e, input int stb, input int bsy);
    chk({tag, ".face"},   int'(bus.face), f);
    chk({tag, ".feed"},   int'(bus.feed_value), fd);
    chk({tag, ".joy"},    int'(bus.joy_value), j);
    chk({tag, ".energy"}, int'(bus.energy_value), e);
    chk({tag, ".strobe"}, int'(bus.update_strobe), stb);
    chk({tag, ".busy"},   int'(bus.busy), bsy);
  endtask

  initial begin
    int stb_cnt;
    int ef, efd, ej, ee, s, chg, tot;
    bus.tick = 1'b0; bus.test_mode = 1'b0;
    bus.face_in = 4'd0; bus.feed_in = 3'd5; bus.joy_in = 3'd5; bus.energy_in = 3'd5;
    do_reset();

    // Reset state, matching inputs: nothing should ever be committed.
    chk_out("rst", 0, 5, 5, 5, 0, 0);
    stb_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      bus.tick = i[0];
      cyc(1);
      stb_cnt += int'(bus.update_strobe);
    end
    bus.tick = 1'b0;
    chk("rst.no_strobe", stb_cnt, 0);
    chk("rst.idle_busy", int'(bus.busy), 0);

    // Two fields change together: face first, feed after HT ticks + 1 clk.
    bus.face_in = 4'd4; bus.feed_in = 3'd2;
    cyc(1);
    chk_out("pri.c1", 4, 5, 5, 5, 1, 1);
    cyc(1);
    chk("pri.strobe_1cyc", int'(bus.update_strobe), 0);
    ticks(2);
    chk("pri.feed_t2", int'(bus.feed_value), 5);
    ticks(1);
    chk_out("pri.t3", 4, 5, 5, 5, 0, 0);
    cyc(1);
    chk_out("pri.feed", 4, 2, 5, 5, 1, 1);

    // Feed request 2->3->1 during the hold: only 1 is ever shown.
    bus.feed_in = 3'd3;
    cyc(1);
    bus.feed_in = 3'd1;
    ticks(HT);
    chk("hold.feed_held", int'(bus.feed_value), 2);
    cyc(1);
    chk_out("hold.final", 4, 1, 5, 5, 1, 1);
    chk("hold.never3", int'(seen3), 0);
    ticks(HT);
    cyc(1);
    chk("hold.quiet", int'(bus.busy), 0);

    // Clamping: face 12 -> 8, joy 7 -> 5 (already 5, so no commit).
    bus.face_in = 4'd12; bus.joy_in = 3'd7;
    cyc(1);
    chk_out("clamp.face", 8, 1, 5, 5, 1, 1);
    ticks(HT);
    cyc(1);
    chk_out("clamp.joy_eq", 8, 1, 5, 5, 0, 0);
    bus.joy_in = 3'd2;
    cyc(1);
    chk("clamp.joy2", int'(bus.joy_value), 2);
    ticks(HT);
    bus.joy_in = 3'd7;
    cyc(1);
    chk_out("clamp.joy7", 8, 1, 5, 5, 1, 1);
    ticks(HT);

    // Reset during HOLD aborts at once.
    bus.face_in = 4'd3;
    cyc(1);
    chk("hrst.commit", int'(bus.face), 3);
    ticks(1);
    bus.face_in = 4'd0; bus.feed_in = 3'd5; bus.joy_in = 3'd5; bus.energy_in = 3'd5;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk_out("hrst", 0, 5, 5, 5, 0, 0);

    // Sweep: steps 1..28, wrap to 0, then on to step 15 and reset there.
    bus.test_mode = 1'b1;
    cyc(1);
    chk_out("sw.s0", 0, 5, 5, 5, 0, 1);
    ef = 0; efd = 5; ej = 5; ee = 5; tot = 0;
    for (int k = 0; k < 44; k++) begin
      s = (k + 1) % 29;
      ticks(HT);
      chg = 0;
      if (s >= 2 && s <= 10)       begin chg = int'(ef != s - 2);   ef = s - 2;   end
      else if (s >= 11 && s <= 16) begin chg = int'(efd != s - 11); efd = s - 11; end
      else if (s >= 17 && s <= 22) begin chg = int'(ej != s - 17);  ej = s - 17;  end
      else if (s >= 23)            begin chg = int'(ee != s - 23);  ee = s - 23;  end
      chk_out($sformatf("sw.k%0d", k), ef, efd, ej, ee, chg, 1);
      if (k < 28) tot += int'(bus.update_strobe);
      if (k == 27) chk("sw.strobes_1st", tot, 26);
    end
    // At step 15 of the second pass: feed=4, joy=energy=5, face=8.
    chk("sw.s15_feed", int'(bus.feed_value), 4);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    bus.test_mode = 1'b0;
    chk_out("trst", 0, 5, 5, 5, 0, 0);

    // Leaving the sweep at a step boundary keeps outputs, then reconverges.
    bus.test_mode = 1'b1;
    cyc(1);
    ticks(3 * HT);
    chk("exit.s3_face", int'(bus.face), 1);
    bus.test_mode = 1'b0;
    ticks(HT - 1);
    chk("exit.mid_busy", int'(bus.busy), 1);
    ticks(1);
    chk_out("exit.idle", 1, 5, 5, 5, 0, 0);
    cyc(1);
    chk_out("exit.reconv", 0, 5, 5, 5, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  // Hard stop guard.
  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
